pi_level_sched: RTL and testbench

- Priority-interrupt scheduler for the 8-level PI system; level 0 is highest priority, level 7 lowest.
- Combines device requests, program-set requests and the level-enable mask, and picks the winning level with priority_encoder8.
- Presents one interrupt at a time to the CPU with a req/ack handshake.
- Tracks held (in-service) levels so that only strictly higher levels can break in.

---
 rtl/pi_pkg.sv | 30 +++
 rtl/priority_encoder8.sv | 21 ++
 rtl/pi_level_sched.sv | 182 ++++++++++++++++++
 tb/tb_pi_level_sched.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pi_pkg.sv
// Shared types and helpers for the 8-level priority-interrupt scheduler.
// Level 0 is the highest priority. Masks use [0:7] ordering, so bit index
// equals level number and the leftmost literal bit is level 0.
package pi_pkg;

  typedef bit [0:2] pi_level_t;
  typedef bit [0:7] pi_mask_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } pi_state_t;

  localparam int unsigned PI_TIMEOUT_DEFAULT = 64;

  // Mask covering the highest-priority set level and every level below it.
  // An all-zero input gives an all-zero mask, so nothing is blocked.
  function automatic pi_mask_t highest_mask(pi_mask_t m);
    pi_mask_t r;
    logic     found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      found = found | m[i];
      r[i]  = found;
    end
    return r;
  endfunction

endpackage

// File: rtl/priority_encoder8.sv
// 8-input priority encoder: index 0 wins.
// Ports:
//   req  [0:7]  request vector, bit index = level
//   enc  [0:2]  lowest set index (0 when nothing is set)
//   any         at least one request bit is set
module priority_encoder8 (
  input  logic [0:7] req,
  output logic [0:2] enc,
  output logic       any
);

  always_comb begin
    enc = 3'd0;
    any = |req;
    // Scan from the lowest priority upward so the last hit is the winner.
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) enc = 3'(i);
    end
  end

endmodule

// File: rtl/pi_level_sched.sv
// Priority-interrupt level scheduler.
// Combines device and program requests with the enable mask, picks the
// highest eligible level and presents it to the CPU with a req/ack
// handshake. Levels in service (held) block themselves and everything of
// lower priority until dismissed.
//
// Optional build macro: PI_TIMEOUT_EN -- withdraws an unacknowledged
// request after TIMEOUT cycles in REQ and pulses timeout.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   dev_req  [0:7]   level-sensitive device requests
//   prog_set [0:7]   pulse, sets program-request bits
//   pio_load         pulse, loads enable mask from pio_data
//   pio_data [0:7]   new enable mask
//   sys_on           PI system enable
//   clear_all        pulse, clears pir, held, pio and aborts any request
//   ack              CPU accepts the presented level
//   dismiss          pulse, CPU finished its highest held level
//   int_req          interrupt request to the CPU
//   int_level [0:2]  level being requested
//   held     [0:7]   in-service levels
//   pir      [0:7]   program-request register
//   timeout          one-cycle pulse when a request is withdrawn on timeout
module pi_level_sched
  import pi_pkg::*;
#(
  parameter int unsigned TIMEOUT = PI_TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [0:7] dev_req,
  input  logic [0:7] prog_set,
  input  logic       pio_load,
  input  logic [0:7] pio_data,
  input  logic       sys_on,
  input  logic       clear_all,
  input  logic       ack,
  input  logic       dismiss,
  output logic       int_req,
  output logic [0:2] int_level,
  output logic [0:7] held,
  output logic [0:7] pir,
  output logic       timeout
);

  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("pi_level_sched: TIMEOUT must be at least 1");
  end

  pi_state_t  state_q, state_d;
  pi_level_t  level_q, level_d;
  pi_mask_t   held_q, held_d;
  pi_mask_t   pir_q, pir_d;
  pi_mask_t   pio_q, pio_d;
  logic       timeout_q, timeout_d;

  logic [0:7] pending;
  logic [0:7] eligible;
  logic [0:2] win_level;
  logic       win_any;
  logic       req_expired;

  // Clears the highest-priority (lowest index) set level.
  function automatic pi_mask_t clear_highest(pi_mask_t m);
    pi_mask_t r;
    logic     done;
    r    = m;
    done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (m[i] && !done) begin
        r[i] = 1'b0;
        done = 1'b1;
      end
    end
    return r;
  endfunction

  assign pending  = sys_on ? ((dev_req | pir_q) & pio_q) : 8'h00;
  assign eligible = pending & ~highest_mask(held_q);

  priority_encoder8 u_pick (
    .req (eligible),
    .enc (win_level),
    .any (win_any)
  );

`ifdef PI_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign req_expired = (state_q == REQ) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Counts REQ cycles without ack; restarts from 0 on every REQ entry.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != REQ || state_d != REQ) cnt_d = '0;
    else                                  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign req_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    held_d    = held_q;
    pir_d     = pir_q;
    pio_d     = pio_q;
    timeout_d = 1'b0;

    if (pio_load) pio_d = pio_data;

    // Dismiss acts on the pre-update held; an ack in the same cycle then
    // sets its own bit on top of the result.
    if (dismiss) held_d = clear_highest(held_q);

    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          level_d = win_level;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          held_d[level_q] = 1'b1;
          pir_d[level_q]  = 1'b0;
          state_d         = IDLE;
        end else if (!sys_on) begin
          state_d = IDLE;
        end else if (req_expired) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new program request beats an ack clear of the same bit.
    pir_d = pir_d | prog_set;

    if (clear_all) begin
      pir_d     = '0;
      held_d    = '0;
      pio_d     = '0;
      state_d   = IDLE;
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      level_q   <= '0;
      held_q    <= '0;
      pir_q     <= '0;
      pio_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      held_q    <= held_d;
      pir_q     <= pir_d;
      pio_q     <= pio_d;
      timeout_q <= timeout_d;
    end
  end

  assign int_req   = (state_q == REQ);
  assign int_level = level_q;
  assign held      = held_q;
  assign pir       = pir_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_pi_level_sched.sv
module tb_pi_level_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [0:7] dev_req;
  logic [0:7] prog_set;
  logic       pio_load;
  logic [0:7] pio_data;
  logic       sys_on;
  logic       clear_all;
  logic       ack;
  logic       dismiss;
  logic       int_req;
  logic [0:2] int_level;
  logic [0:7] held;
  logic [0:7] pir;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  pi_level_sched #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .dev_req   (dev_req),
    .prog_set  (prog_set),
    .pio_load  (pio_load),
    .pio_data  (pio_data),
    .sys_on    (sys_on),
    .clear_all (clear_all),
    .ack       (ack),
    .dismiss   (dismiss),
    .int_req   (int_req),
    .int_level (int_level),
    .held      (held),
    .pir       (pir),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; dev_req = '0; prog_set = '0; pio_load = 1'b0; pio_data = '0;
    sys_on = 1'b0; clear_all = 1'b0; ack = 1'b0; dismiss = 1'b0;
    tick(); tick();
    checks++;
    if ({int_req, int_level, held, pir, timeout} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs got req=%0b lvl=%0d held=%b pir=%b to=%0b exp all 0",
               int_req, int_level, held, pir, timeout);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_grant();
    sys_on = 1'b1; pio_load = 1'b1; pio_data = 8'hFF;
    tick();
    pio_load = 1'b0;
    dev_req = 8'b00010000;
    #1;
    checks++;
    if (int_req !== 1'b0) begin
      errors++; $display("FAIL basic_latency got int_req=%0b exp 0", int_req);
    end
    tick();
    checks++;
    if ({int_req, int_level} !== 4'b1_011) begin
      errors++; $display("FAIL basic_req got req=%0b lvl=%0d exp req=1 lvl=3", int_req, int_level);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if ({int_req, held} !== {1'b0, 8'b00010000}) begin
      errors++; $display("FAIL basic_ack got req=%0b held=%b exp req=0 held=00010000", int_req, held);
    end
  endtask

  task automatic test_held_block();
    dev_req = 8'b00000100;
    tick(); tick(); tick();
    checks++;
    if (int_req !== 1'b0) begin
      errors++; $display("FAIL held_blocks_lower got int_req=%0b exp 0", int_req);
    end
    dev_req = 8'b01000100;
    tick();
    checks++;
    if ({int_req, int_level} !== 4'b1_001) begin
      errors++; $display("FAIL held_breakin got req=%0b lvl=%0d exp req=1 lvl=1", int_req, int_level);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (held !== 8'b01010000) begin
      errors++; $display("FAIL held_breakin_ack got held=%b exp 01010000", held);
    end
  endtask

  task automatic test_dismiss_with_ack();
    dev_req = 8'b10000000;
    tick();
    checks++;
    if ({int_req, int_level} !== 4'b1_000) begin
      errors++; $display("FAIL dis_ack_req got req=%0b lvl=%0d exp req=1 lvl=0", int_req, int_level);
    end
    ack = 1'b1; dismiss = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (held !== 8'b10010000) begin
      errors++; $display("FAIL dis_ack_held got held=%b exp 10010000", held);
    end
    dev_req = 8'b00000000;
    tick();
    checks++;
    if (held !== 8'b00010000) begin
      errors++; $display("FAIL dismiss_one got held=%b exp 00010000", held);
    end
    tick();
    checks++;
    if (held !== 8'b00000000) begin
      errors++; $display("FAIL dismiss_two got held=%b exp 00000000", held);
    end
    tick();
    dismiss = 1'b0;
    checks++;
    if ({held, int_req} !== 9'd0) begin
      errors++; $display("FAIL dismiss_empty got held=%b req=%0b exp held=0 req=0", held, int_req);
    end
  endtask

  task automatic test_no_rearb();
    dev_req = 8'b00001000;
    tick();
    checks++;
    if ({int_req, int_level} !== 4'b1_100) begin
      errors++; $display("FAIL norearb_req got req=%0b lvl=%0d exp req=1 lvl=4", int_req, int_level);
    end
    dev_req = 8'b10001000;
    tick(); tick();
    checks++;
    if ({int_req, int_level} !== 4'b1_100) begin
      errors++; $display("FAIL norearb_hold got req=%0b lvl=%0d exp req=1 lvl=4", int_req, int_level);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if ({int_req, held} !== {1'b0, 8'b00001000}) begin
      errors++; $display("FAIL norearb_ack got req=%0b held=%b exp req=0 held=00001000", int_req, held);
    end
    tick();
    checks++;
    if ({int_req, int_level} !== 4'b1_000) begin
      errors++; $display("FAIL norearb_next got req=%0b lvl=%0d exp req=1 lvl=0", int_req, int_level);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0; dev_req = '0; dismiss = 1'b1;
    tick(); tick();
    dismiss = 1'b0;
    checks++;
    if ({held, int_req} !== 9'd0) begin
      errors++; $display("FAIL norearb_cleanup got held=%b req=%0b exp 0", held, int_req);
    end
  endtask

  task automatic test_sys_off();
    dev_req = 8'b00100000;
    tick();
    sys_on = 1'b0;
    tick();
    checks++;
    if ({int_req, held} !== 9'd0) begin
      errors++; $display("FAIL sysoff_withdraw got req=%0b held=%b exp req=0 held=0", int_req, held);
    end
    tick(); tick();
    checks++;
    if (int_req !== 1'b0) begin
      errors++; $display("FAIL sysoff_gate got int_req=%0b exp 0", int_req);
    end
    sys_on = 1'b1;
    tick();
    ack = 1'b1; sys_on = 1'b0;
    tick();
    ack = 1'b0; sys_on = 1'b1; dev_req = '0;
    checks++;
    if ({int_req, held} !== {1'b0, 8'b00100000}) begin
      errors++; $display("FAIL ack_beats_sysoff got req=%0b held=%b exp req=0 held=00100000", int_req, held);
    end
    dismiss = 1'b1;
    tick();
    dismiss = 1'b0;
  endtask

  task automatic test_prog_and_clear();
    pio_load = 1'b1; pio_data = 8'h00;
    tick();
    pio_load = 1'b0; prog_set = 8'b00000010;
    tick();
    prog_set = '0;
    checks++;
    if (pir !== 8'b00000010) begin
      errors++; $display("FAIL prog_set_pir got pir=%b exp 00000010", pir);
    end
    tick(); tick();
    checks++;
    if (int_req !== 1'b0) begin
      errors++; $display("FAIL prog_masked got int_req=%0b exp 0", int_req);
    end
    pio_load = 1'b1; pio_data = 8'h02;
    tick();
    pio_load = 1'b0;
    checks++;
    if (int_req !== 1'b0) begin
      errors++; $display("FAIL pio_delay got int_req=%0b exp 0", int_req);
    end
    tick();
    checks++;
    if ({int_req, int_level} !== 4'b1_110) begin
      errors++; $display("FAIL prog_req got req=%0b lvl=%0d exp req=1 lvl=6", int_req, int_level);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if ({pir, held} !== {8'b00000000, 8'b00000010}) begin
      errors++; $display("FAIL prog_ack got pir=%b held=%b exp pir=00000000 held=00000010", pir, held);
    end
    dismiss = 1'b1; prog_set = 8'b00000010;
    tick();
    dismiss = 1'b0; prog_set = '0;
    tick();
    checks++;
    if ({int_req, int_level} !== 4'b1_110) begin
      errors++; $display("FAIL prog_rereq got req=%0b lvl=%0d exp req=1 lvl=6", int_req, int_level);
    end
    ack = 1'b1; prog_set = 8'b00000010;
    tick();
    ack = 1'b0; prog_set = '0;
    checks++;
    if ({pir, held} !== {8'b00000010, 8'b00000010}) begin
      errors++; $display("FAIL set_beats_ack got pir=%b held=%b exp pir=00000010 held=00000010", pir, held);
    end
    dismiss = 1'b1;
    tick();
    dismiss = 1'b0;
    tick();
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    checks++;
    if ({int_req, pir, held} !== 17'd0) begin
      errors++; $display("FAIL clear_all got req=%0b pir=%b held=%b exp all 0", int_req, pir, held);
    end
    dev_req = 8'b10000000;
    tick(); tick();
    dev_req = '0;
    checks++;
    if (int_req !== 1'b0) begin
      errors++; $display("FAIL clear_all_pio got int_req=%0b exp 0", int_req);
    end
  endtask

  task automatic test_timeout();
    pio_load = 1'b1; pio_data = 8'hFF;
    tick();
    pio_load = 1'b0; dev_req = 8'b00100000;
    tick();
    tick(); tick(); tick();
`ifdef PI_TIMEOUT_EN
    checks++;
    if ({int_req, timeout} !== 2'b10) begin
      errors++; $display("FAIL to_last_req got req=%0b to=%0b exp req=1 to=0", int_req, timeout);
    end
    tick();
    checks++;
    if ({int_req, timeout} !== 2'b01) begin
      errors++; $display("FAIL to_pulse got req=%0b to=%0b exp req=0 to=1", int_req, timeout);
    end
    tick();
    checks++;
    if ({int_req, int_level, timeout, held} !== {1'b1, 3'd2, 1'b0, 8'b00000000}) begin
      errors++; $display("FAIL to_rereq got req=%0b lvl=%0d to=%0b held=%b exp req=1 lvl=2 to=0 held=0",
                         int_req, int_level, timeout, held);
    end
`else
    tick(); tick(); tick(); tick(); tick();
    checks++;
    if ({int_req, int_level, timeout} !== {1'b1, 3'd2, 1'b0}) begin
      errors++; $display("FAIL no_timeout got req=%0b lvl=%0d to=%0b exp req=1 lvl=2 to=0",
                         int_req, int_level, timeout);
    end
`endif
  endtask

  task automatic test_async_reset();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({int_req, int_level, held, pir, timeout} !== 21'd0) begin
      errors++; $display("FAIL async_reset got req=%0b lvl=%0d held=%b pir=%b to=%0b exp all 0",
                         int_req, int_level, held, pir, timeout);
    end
    dev_req = '0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_grant();
    test_held_block();
    test_dismiss_with_ack();
    test_no_rearb();
    test_sys_off();
    test_prog_and_clear();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
